nic_endpoint: RTL and testbench
===============================

Name: nic_endpoint

Overview:
Network interface controller that terminates the processor's NIC access port (nicEn / nicEnWr / adder_nic / nic_dataIn / nic_dataOut) and bridges it to one router port.
- Holds a one-entry input channel buffer (ICB), filled by the router and drained by processor loads.
- Holds a one-entry output channel buffer (OCB), filled by processor stores and drained by the router.
- Each buffer has a full flag. The processor polls the flags through status registers.

Parameters:
DATA_WIDTH, 64, width of processor data, router data and both channel buffers
ADDR_WIDTH, 2, width of the NIC register select

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
nicEn  input  1  processor NIC access enable, one access per asserted cycle
nicEnWr  input  1  access type: 1 = write, 0 = read; qualified by nicEn
adder_nic  input  ADDR_WIDTH  register select: 00 ICB, 01 in-status, 10 OCB, 11 out-status
nic_dataIn  input  DATA_WIDTH  processor write data
nic_dataOut  output  DATA_WIDTH  processor read data, registered
net_si  input  1  router offers a packet to the NIC
net_ri  output  1  NIC can accept a packet (= ~in_full, combinational)
net_di  input  DATA_WIDTH  router packet data
net_so  output  1  NIC offers a packet to the router (= out_full)
net_ro  input  1  router can accept a packet
net_do  output  DATA_WIDTH  outgoing packet (= OCB contents)

Behaviour:
- Reset (async, rst=1): ICB, OCB, in_full, out_full and nic_dataOut clear to 0. Outputs become net_ri=1, net_so=0, net_do=0. Any packet buffered when reset asserts is discarded. Reset overrides all same-cycle events.
- Processor read (nicEn=1, nicEnWr=0):
  - nic_dataOut updates at the next rising edge with the selected register: 1-cycle latency, matching the processor's stage-2 issue / stage-3 capture.
  - 00 returns ICB. If in_full=1, it also clears in_full (pop). If in_full=0, it returns stale ICB contents with no state change.
  - 01 returns {63'b0, in_full}.
  - 10 returns OCB, with no state change.
  - 11 returns {63'b0, out_full}.
  - nic_dataOut holds its value in every cycle without a read.
- Processor write (nicEn=1, nicEnWr=1):
  - 10 with out_full=0: OCB<=nic_dataIn and out_full<=1.
  - 10 with out_full=1: write dropped, OCB unchanged. Software must poll 11 first.
  - Writes to 00, 01 and 11 are ignored.
  - nic_dataOut is unchanged on writes.
- nicEn=0: nicEnWr and adder_nic are don't-care, and processor-side state is unchanged.
- Router input: on a rising edge with net_si=1 and net_ri=1, ICB<=net_di and in_full<=1.
  - net_ri drops combinationally while full. net_di is ignored when net_ri=0.
- Router output: net_so=out_full and net_do=OCB. On a rising edge with net_so=1 and net_ro=1, out_full<=0. OCB keeps its data.
- Simultaneous events:
  - ICB pop and router delivery cannot coincide, because delivery requires in_full=0 and pop requires in_full=1. The earliest refill is the edge after the pop edge.
  - Router drain and processor OCB write in the same cycle: out_full=1, so the write is dropped. The earliest accepted write is the next cycle.
  - In-status read in the same cycle as a router delivery returns the pre-edge value (0).
- Throughput: one packet per 2 cycles per direction in steady state.
- Flags only change through the events above. No combinational path from nicEn or adder_nic to any router-side output.

Test Plan:
- Reset: assert rst mid-cycle while in_full=1 and out_full=1 -> flags clear immediately; net_ri=1, net_so=0, nic_dataOut=0.
- Router-to-processor:
  - net_si=1, net_di=64'hDEAD_BEEF_0000_0001 -> next edge in_full=1, net_ri=0.
  - Read 01 -> nic_dataOut=1 one cycle later.
  - Read 00 -> nic_dataOut=64'hDEAD_BEEF_0000_0001, then in_full=0 and net_ri=1.
- ICB backpressure: in_full=1, net_si=1, net_di=64'h5 held for 3 cycles -> ICB keeps original data and net_ri stays 0. After the pop, 64'h5 is captured on the following edge.
- Processor-to-router, net_ro=0:
  - Write 10 with 64'h0123_4567_89AB_CDEF -> net_so=1, net_do=64'h0123_4567_89AB_CDEF.
  - Second write 64'hFF -> dropped, net_do unchanged.
  - Read 11 -> 1.
- Drain/write collision: out_full=1; assert net_ro=1 and write 10 with 64'h7 in the same cycle -> out_full=0 and OCB unchanged. Repeating the write next cycle -> OCB=64'h7, net_so=1.
- Ignored accesses: write 00/01/11 with 64'hAA -> no state change. Read 00 while empty -> stale ICB, in_full stays 0.

Source files
------------

// File: rtl/nic_endpoint.sv
// NIC endpoint: bridges the processor's NIC access port to one router port through
// one-entry input (ICB) and output (OCB) channel buffers with polled full flags.
module nic_endpoint #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic [ADDR_WIDTH-1:0] adder_nic,
    input  logic [DATA_WIDTH-1:0] nic_dataIn,
    output logic [DATA_WIDTH-1:0] nic_dataOut,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do
);

    localparam logic [ADDR_WIDTH-1:0] SelIcb   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] SelInSt  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] SelOcb   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] SelOutSt = ADDR_WIDTH'(3);

    logic [DATA_WIDTH-1:0] icb_q, icb_d;
    logic [DATA_WIDTH-1:0] ocb_q, ocb_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  in_full_q, in_full_d;
    logic                  out_full_q, out_full_d;

    logic proc_rd;
    logic proc_wr;
    logic net_accept;
    logic net_drain;

    assign proc_rd    = nicEn & ~nicEnWr;
    assign proc_wr    = nicEn & nicEnWr;
    assign net_accept = net_si & ~in_full_q;
    assign net_drain  = out_full_q & net_ro;

    always_comb begin
        icb_d      = icb_q;
        ocb_d      = ocb_q;
        dout_d     = dout_q;
        in_full_d  = in_full_q;
        out_full_d = out_full_q;

        // Delivery needs in_full=0 and a pop needs in_full=1, so these never collide.
        if (net_accept) begin
            icb_d     = net_di;
            in_full_d = 1'b1;
        end

        if (net_drain) begin
            out_full_d = 1'b0;
        end

        if (proc_rd) begin
            case (adder_nic)
                SelIcb: begin
                    dout_d = icb_q;
                    if (in_full_q) begin
                        in_full_d = 1'b0;
                    end
                end
                SelInSt:  dout_d = DATA_WIDTH'(in_full_q);
                SelOcb:   dout_d = ocb_q;
                SelOutSt: dout_d = DATA_WIDTH'(out_full_q);
                default:  dout_d = dout_q;
            endcase
        end

        // A write landing on the drain cycle still sees out_full=1 and is dropped.
        if (proc_wr && (adder_nic == SelOcb) && !out_full_q) begin
            ocb_d      = nic_dataIn;
            out_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icb_q      <= '0;
            ocb_q      <= '0;
            dout_q     <= '0;
            in_full_q  <= 1'b0;
            out_full_q <= 1'b0;
        end else begin
            icb_q      <= icb_d;
            ocb_q      <= ocb_d;
            dout_q     <= dout_d;
            in_full_q  <= in_full_d;
            out_full_q <= out_full_d;
        end
    end

    assign nic_dataOut = dout_q;
    assign net_ri      = ~in_full_q;
    assign net_so      = out_full_q;
    assign net_do      = ocb_q;

endmodule

// File: tb/tb_nic_endpoint.sv
// Bench for nic_endpoint: directed scenarios plus random traffic against a queue-based
// model of the two one-entry channel buffers.
module tb_nic_endpoint;

    logic        clk;
    logic        rst;
    logic        nicEn;
    logic        nicEnWr;
    logic [1:0]  adder_nic;
    logic [63:0] nic_dataIn;
    logic [63:0] nic_dataOut;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: each buffer is a queue holding at most one packet.
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] icb_last;
    logic [63:0] ocb_last;
    logic [63:0] m_dout;

    nic_endpoint #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nicEn      (nicEn),
        .nicEnWr    (nicEnWr),
        .adder_nic  (adder_nic),
        .nic_dataIn (nic_dataIn),
        .nic_dataOut(nic_dataOut),
        .net_si     (net_si),
        .net_ri     (net_ri),
        .net_di     (net_di),
        .net_so     (net_so),
        .net_ro     (net_ro),
        .net_do     (net_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        icb_last = '0;
        ocb_last = '0;
        m_dout   = '0;
    endtask

    task automatic proc(input logic en, input logic wr, input logic [1:0] a,
                        input logic [63:0] d);
        nicEn      = en;
        nicEnWr    = wr;
        adder_nic  = a;
        nic_dataIn = d;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".dout"}, nic_dataOut, m_dout);
        check_eq({tag, ".ri"}, {63'b0, net_ri}, {63'b0, in_q.size() == 0});
        check_eq({tag, ".so"}, {63'b0, net_so}, {63'b0, out_q.size() != 0});
        check_eq({tag, ".do"}, net_do, ocb_last);
    endtask

    // Advance one clock: predict the effect of the current inputs, then compare.
    task automatic tick(input string tag);
        logic        in_full;
        logic        out_full;
        logic        pop;
        logic        accept;
        logic        drain;
        logic        wr_ok;
        logic [63:0] nd;
        logic [63:0] di_s;
        logic [63:0] din_s;
        in_full  = in_q.size() != 0;
        out_full = out_q.size() != 0;
        nd       = m_dout;
        pop      = 1'b0;
        accept   = net_si && !in_full;
        drain    = out_full && net_ro;
        wr_ok    = nicEn && nicEnWr && adder_nic == 2'd2 && !out_full;
        di_s     = net_di;
        din_s    = nic_dataIn;
        if (nicEn && !nicEnWr) begin
            case (adder_nic)
                2'd0: begin nd = icb_last; pop = in_full; end
                2'd1: nd = {63'b0, in_full};
                2'd2: nd = ocb_last;
                default: nd = {63'b0, out_full};
            endcase
        end
        @(posedge clk);
        #1;
        if (pop) void'(in_q.pop_front());
        if (accept) begin in_q.push_back(di_s); icb_last = di_s; end
        if (drain) void'(out_q.pop_front());
        if (wr_ok) begin out_q.push_back(din_s); ocb_last = din_s; end
        m_dout = nd;
        check_outputs(tag);
    endtask

    initial begin
        rst    = 1'b1;
        proc(1'b0, 1'b0, 2'd0, '0);
        net_si = 1'b0;
        net_di = '0;
        net_ro = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("reset.ri", {63'b0, net_ri}, 64'd1);
        check_eq("reset.so", {63'b0, net_so}, 64'd0);
        check_eq("reset.dout", nic_dataOut, 64'd0);
        check_eq("reset.do", net_do, 64'd0);

        // Router to processor
        net_si = 1'b1;
        net_di = 64'hDEAD_BEEF_0000_0001;
        tick("deliver");
        net_si = 1'b0;
        check_eq("deliver.ri0", {63'b0, net_ri}, 64'd0);
        proc(1'b1, 1'b0, 2'd1, '0);
        tick("rd_instat");
        check_eq("rd_instat.val", nic_dataOut, 64'd1);
        proc(1'b1, 1'b0, 2'd0, '0);
        tick("rd_icb");
        check_eq("rd_icb.val", nic_dataOut, 64'hDEAD_BEEF_0000_0001);
        check_eq("rd_icb.ri1", {63'b0, net_ri}, 64'd1);
        proc(1'b0, 1'b0, 2'd0, '0);

        // ICB backpressure
        net_si = 1'b1;
        net_di = 64'hCAFE;
        tick("bp_fill");
        net_di = 64'h5;
        repeat (3) tick("bp_hold");
        check_eq("bp.ri0", {63'b0, net_ri}, 64'd0);
        proc(1'b1, 1'b0, 2'd0, '0);
        tick("bp_pop");
        check_eq("bp_pop.val", nic_dataOut, 64'hCAFE);
        proc(1'b0, 1'b0, 2'd0, '0);
        tick("bp_refill");
        net_si = 1'b0;
        check_eq("bp_refill.ri0", {63'b0, net_ri}, 64'd0);
        proc(1'b1, 1'b0, 2'd0, '0);
        tick("bp_rd5");
        check_eq("bp_rd5.val", nic_dataOut, 64'h5);
        proc(1'b0, 1'b0, 2'd0, '0);

        // Processor to router, router stalled
        proc(1'b1, 1'b1, 2'd2, 64'h0123_4567_89AB_CDEF);
        tick("wr_ocb");
        check_eq("wr_ocb.do", net_do, 64'h0123_4567_89AB_CDEF);
        check_eq("wr_ocb.so", {63'b0, net_so}, 64'd1);
        proc(1'b1, 1'b1, 2'd2, 64'hFF);
        tick("wr_drop");
        check_eq("wr_drop.do", net_do, 64'h0123_4567_89AB_CDEF);
        proc(1'b1, 1'b0, 2'd3, '0);
        tick("rd_outstat");
        check_eq("rd_outstat.val", nic_dataOut, 64'd1);

        // Drain and write in the same cycle
        net_ro = 1'b1;
        proc(1'b1, 1'b1, 2'd2, 64'h7);
        tick("collide");
        check_eq("collide.so", {63'b0, net_so}, 64'd0);
        check_eq("collide.do", net_do, 64'h0123_4567_89AB_CDEF);
        net_ro = 1'b0;
        tick("rewrite");
        check_eq("rewrite.do", net_do, 64'h7);
        check_eq("rewrite.so", {63'b0, net_so}, 64'd1);

        // Ignored writes and stale ICB read
        for (int a = 0; a < 4; a++) begin
            if (a != 2) begin
                proc(1'b1, 1'b1, 2'(a), 64'hAA);
                tick("wr_ignored");
            end
        end
        proc(1'b1, 1'b0, 2'd0, '0);
        tick("rd_stale");
        check_eq("rd_stale.val", nic_dataOut, 64'h5);
        check_eq("rd_stale.ri", {63'b0, net_ri}, 64'd1);

        // Asynchronous reset mid-cycle with both buffers full
        net_si = 1'b1;
        net_di = 64'h1234;
        proc(1'b1, 1'b0, 2'd3, '0);
        tick("pre_rst");
        net_si = 1'b0;
        proc(1'b0, 1'b0, 2'd0, '0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_eq("async_rst.ri", {63'b0, net_ri}, 64'd1);
        check_eq("async_rst.so", {63'b0, net_so}, 64'd0);
        check_eq("async_rst.dout", nic_dataOut, 64'd0);
        check_eq("async_rst.do", net_do, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_outputs("post_rst");

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            proc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom});
            net_si = 1'($urandom_range(0, 1));
            net_di = {$urandom, $urandom};
            net_ro = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
